// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - 8-phase instruction sequencer for the 8-bit accumulator CPU
module cpu_controller #(
    parameter bit WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       resume,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_e phase_q;
    phase_e phase_d;
    logic   halted_q;
    logic   halted_d;

    logic   aluop;
    logic   is_hlt;
    logic   is_skz;
    logic   is_sto;
    logic   is_jmp;

    // Opcode class decode; only the ALU-type ops read memory in the operand half
    always_comb begin
        aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);
        is_hlt = (opcode == OP_HLT);
        is_skz = (opcode == OP_SKZ);
        is_sto = (opcode == OP_STO);
        is_jmp = (opcode == OP_JMP);
    end

    // Phase and halted-flag registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next state: one phase per clock, memory wait holds, halt entry and resume
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (halted_q) begin
            // phase_q is parked at INST_ADDR while halted, so resume restarts cleanly
            if (resume) begin
                phase_d  = INST_ADDR;
                halted_d = 1'b0;
            end
        end else begin
            case (phase_q)
                INST_FETCH: begin
                    if (!(WAIT_EN && !mem_ready)) begin
                        phase_d = INST_LOAD;
                    end
                end
                OP_ADDR: begin
                    if (is_hlt) begin
                        phase_d  = INST_ADDR;
                        halted_d = 1'b1;
                    end else begin
                        phase_d = OP_FETCH;
                    end
                end
                OP_FETCH: begin
                    // Non-ALU ops issue no read here, so there is nothing to wait for
                    if (!(WAIT_EN && aluop && !mem_ready)) begin
                        phase_d = ALU_OP;
                    end
                end
                default: begin
                    phase_d = phase_e'(phase_q + 3'd1);
                end
            endcase
        end
    end

    // Strobe decode from registered phase plus opcode/zero
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = is_skz && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    // Debug phase: HALTED is reported as 7 alongside halt=1
    assign phase = halted_q ? 3'd7 : phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard testbench for cpu_controller
module tb_cpu_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       resume;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;

    cpu_controller #(.WAIT_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .resume    (resume),
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .inc_pc    (inc_pc),
        .ld_pc     (ld_pc),
        .ld_ac     (ld_ac),
        .wr        (wr),
        .data_e    (data_e),
        .halt      (halt),
        .phase     (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    typedef struct {
        logic [11:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    int   wr_cnt, inc_cnt, ldpc_cnt, ldac_cnt, ph1_cnt, ph5_cnt, ldir_cnt, halt_cnt;

    logic [2:0] m_ph;
    logic       m_hl;

    // {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase}
    function automatic logic [11:0] exp_out(logic [2:0] ph, logic hl, logic [2:0] op, logic z);
        logic alu;
        logic s, r, li, ip, lp, la, w, de, h;
        alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
        {s, r, li, ip, lp, la, w, de, h} = 9'b0;
        if (hl) return {9'b000000001, 3'd7};
        case (ph)
            3'd0: s = 1;
            3'd1: begin s = 1; r = 1; end
            3'd2, 3'd3: begin s = 1; r = 1; li = 1; end
            3'd4: begin ip = 1; h = (op == HLT); end
            3'd5: r = alu;
            3'd6: begin r = alu; ip = (op == SKZ) && z; lp = (op == JMP); de = (op == STO); end
            default: begin r = alu; la = alu; lp = (op == JMP); w = (op == STO); de = (op == STO); end
        endcase
        return {s, r, li, ip, lp, la, w, de, h, ph};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock of stimulus: drive inputs, push expected outputs, advance the model
    task automatic cyc(input logic [2:0] op, input logic z, input logic mr, input logic res, input string tag);
        exp_t e;
        logic [2:0] nph;
        logic       nhl;
        logic       alu;
        opcode = op; zero = z; mem_ready = mr; resume = res;
        e.v = exp_out(m_ph, m_hl, op, z);
        e.tag = tag;
        q.push_back(e);
        alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
        nph = m_ph; nhl = m_hl;
        if (!rst_n) begin
            nph = 0; nhl = 0;
        end else if (m_hl) begin
            if (res) begin nph = 0; nhl = 0; end
        end else if (m_ph == 3'd4 && op == HLT) begin
            nph = 0; nhl = 1;
        end else if (m_ph == 3'd1 && !mr) begin
            nph = 3'd1;
        end else if (m_ph == 3'd5 && alu && !mr) begin
            nph = 3'd5;
        end else begin
            nph = m_ph + 3'd1;
        end
        @(posedge clk);
        #1;
        m_ph = nph;
        m_hl = nhl;
    endtask

    task automatic clr_cnt();
        wr_cnt = 0; inc_cnt = 0; ldpc_cnt = 0; ldac_cnt = 0;
        ph1_cnt = 0; ph5_cnt = 0; ldir_cnt = 0; halt_cnt = 0;
    endtask

    // Runs one instruction from phase 0; w1/w5 are mem_ready-low cycles in phases 1/5
    task automatic run_instr(input logic [2:0] op, input logic z, input int w1, input int w5, input string tag);
        int guard = 0;
        logic mr;
        do begin
            mr = 1'b1;
            if (m_ph == 3'd1 && w1 > 0) begin mr = 1'b0; w1--; end
            if (m_ph == 3'd5 && w5 > 0) begin mr = 1'b0; w5--; end
            cyc(op, z, mr, 1'b0, tag);
            guard++;
        end while (m_ph != 3'd0 && !m_hl && guard < 40);
        if (guard >= 40) chk({tag, "_timeout"}, guard, 0);
    endtask

    // Monitor: compare every cycle against the scoreboard, plus the exclusion rules
    always @(negedge clk) begin
        exp_t e;
        logic [11:0] act;
        act = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};
        if (q.size() > 0) begin
            e = q.pop_front();
            n_total++;
            if (act === e.v) n_pass++;
            else $display("FAIL %s: outputs got %03h expected %03h", e.tag, act, e.v);
            n_total++;
            if (!(wr && ld_ac)) n_pass++;
            else $display("FAIL %s_wr_ldac_excl: got wr=%b ld_ac=%b expected not both", e.tag, wr, ld_ac);
            n_total++;
            if (!(ld_pc && inc_pc)) n_pass++;
            else $display("FAIL %s_ldpc_incpc_excl: got ld_pc=%b inc_pc=%b expected not both", e.tag, ld_pc, inc_pc);
            if (wr) wr_cnt++;
            if (inc_pc) inc_cnt++;
            if (ld_pc) ldpc_cnt++;
            if (ld_ac) ldac_cnt++;
            if (ld_ir) ldir_cnt++;
            if (halt) halt_cnt++;
            if (phase == 3'd1 && !halt) ph1_cnt++;
            if (phase == 3'd5 && !halt) ph5_cnt++;
        end
    end

    initial begin
        rst_n = 1'b0; opcode = ADD; zero = 1'b0; mem_ready = 1'b1; resume = 1'b0;
        m_ph = 0; m_hl = 0;
        clr_cnt();
        @(posedge clk);
        #1;
        cyc(ADD, 0, 1, 0, "reset");
        cyc(ADD, 0, 1, 1, "reset_resume");
        rst_n = 1'b1;

        // 1: ADD straight through
        clr_cnt();
        run_instr(ADD, 0, 0, 0, "add");
        chk("add_ldir_cycles", ldir_cnt, 2);
        chk("add_incpc_cycles", inc_cnt, 1);
        chk("add_ldac_cycles", ldac_cnt, 1);
        chk("add_back_to_ph0", m_ph, 0);

        // 2: STO
        clr_cnt();
        run_instr(STO, 0, 0, 0, "sto");
        chk("sto_wr_cycles", wr_cnt, 1);
        chk("sto_ldac_cycles", ldac_cnt, 0);

        // 3: SKZ / JMP
        clr_cnt();
        run_instr(SKZ, 1, 0, 0, "skz_z1");
        chk("skz_z1_incpc", inc_cnt, 2);
        clr_cnt();
        run_instr(SKZ, 0, 0, 0, "skz_z0");
        chk("skz_z0_incpc", inc_cnt, 1);
        clr_cnt();
        run_instr(JMP, 0, 0, 0, "jmp");
        chk("jmp_ldpc", ldpc_cnt, 2);
        chk("jmp_incpc", inc_cnt, 1);

        // 4: wait states
        clr_cnt();
        run_instr(XOR_, 0, 3, 0, "wait_ph1");
        chk("wait_ph1_cycles", ph1_cnt, 4);
        clr_cnt();
        run_instr(LDA, 0, 0, 2, "wait_ph5_lda");
        chk("wait_ph5_lda_cycles", ph5_cnt, 3);
        clr_cnt();
        run_instr(STO, 0, 0, 3, "nowait_ph5_sto");
        chk("nowait_ph5_sto_cycles", ph5_cnt, 1);
        chk("nowait_ph5_sto_wr", wr_cnt, 1);

        // resume outside HALTED is ignored
        cyc(AND_, 0, 1, 1, "resume_ignored");
        run_instr(AND_, 0, 0, 0, "and_after_resume");

        // 5: HLT and resume
        clr_cnt();
        run_instr(HLT, 0, 0, 0, "hlt");
        for (int i = 0; i < 20; i++) cyc(ADD, 1, 1, 0, "halted");
        chk("halt_cycles", halt_cnt, 21);
        cyc(ADD, 0, 1, 1, "resume_pulse");
        cyc(ADD, 0, 1, 0, "after_resume_ph0");
        while (m_ph != 3'd0) cyc(ADD, 0, 1, 0, "finish_add");

        // 6: async reset mid phase 6 of STO
        clr_cnt();
        while (m_ph != 3'd6) cyc(STO, 0, 1, 0, "sto_pre_reset");
        #1;
        rst_n = 1'b0;
        m_ph = 0; m_hl = 0;
        cyc(STO, 0, 1, 0, "async_reset");
        cyc(STO, 0, 1, 0, "async_reset_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(STO, 0, 1, 0, "post_reset");
        chk("no_wr_around_reset", wr_cnt, 0);
        while (m_ph != 3'd0) cyc(STO, 0, 1, 0, "post_reset_sto");

        // random run
        for (int i = 0; i < 400; i++) begin
            cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), "random");
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
